// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and sizing helpers for the async_fifo read-side stream adapter.
package fifo_rd_stream_pkg;

    // Default data width; keep in step with async_fifo.
    localparam int FIFO_WIDTH_DEFAULT = 32;

    // Adapter operating state.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // Pointer width for a buffer of 'depth' entries; counters use one extra bit
    // so they can hold the value 'depth' itself.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular register buffer that soaks up words already requested from
// async_fifo. Head entry is presented straight from registers, so nothing on
// the write side reaches head_data combinationally. 'clear' empties the buffer
// and wins over push/pop in the same cycle.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    occupancy
);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    occ_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (occ_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Capture the incoming word when this slot is the tail.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (do_push && (tail_reg == PW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else if (clear) begin
            head_reg <= tail_reg;
            occ_reg  <= '0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (do_pop) begin
                head_reg <= head_reg + PW'(1);
            end
            if (do_push && !do_pop) begin
                occ_reg <= occ_reg + CW'(1);
            end else if (!do_push && do_pop) begin
                occ_reg <= occ_reg - CW'(1);
            end
        end
    end

    assign head_data = entry_q[head_reg];
    assign occupancy = occ_reg;

    // The upstream credit scheme must never let a push land on a full buffer.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (occ_reg == CW'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for async_fifo in the rd_clk domain: issues rd_en against
// a credit budget, parks returning words in a skid buffer and presents them as
// a valid/ready stream. flush discards buffered and in-flight words.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds word_count / stall_count.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH_DEFAULT,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic             rd_clk,
    input  logic             async_rst_n,
    input  logic             empty,
    output logic             rd_en,
    input  logic             rd_valid,
    input  logic [WIDTH-1:0] rd_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic             err_unexpected
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]      word_count,
    output logic [31:0]      stall_count
`endif
);

    localparam int PW = ptr_width(SKID_DEPTH);
    localparam int CW = PW + 1;

    generate
        if ((RD_LATENCY < 1) || (RD_LATENCY > 3) || (SKID_DEPTH < RD_LATENCY + 1) ||
            ((SKID_DEPTH & (SKID_DEPTH - 1)) != 0)) begin : g_bad_cfg
            $error("fifo_rd_stream: illegal RD_LATENCY / SKID_DEPTH combination");
        end
    endgenerate

    rd_state_t        state_reg;
    rd_state_t        state_next;
    logic [CW-1:0]    out_reg;
    logic             err_reg;
    logic [CW-1:0]    occupancy;
    logic [WIDTH-1:0] head_data;
    logic             credit_ok;
    logic             rd_accept;
    logic             unexpected;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_clear;

    // Buffered words plus words still in flight must fit in the skid buffer.
    assign credit_ok  = ({1'b0, occupancy} + {1'b0, out_reg}) < (CW + 1)'(SKID_DEPTH);
    assign rd_en      = async_rst_n && (state_reg == RUN) && !empty && credit_ok;

    // A returning word only counts against a real outstanding request.
    assign rd_accept  = rd_valid && (out_reg != '0);
    assign unexpected = rd_valid && (out_reg == '0);

    assign buf_push   = rd_accept && (state_reg == RUN);
    assign buf_pop    = m_valid && m_ready;
    assign buf_clear  = flush && (state_reg == RUN);

    assign m_valid        = (occupancy != '0);
    assign m_data         = head_data;
    assign err_unexpected = err_reg;

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst_n     (async_rst_n),
        .push      (buf_push),
        .push_data (rd_data),
        .pop       (buf_pop),
        .clear     (buf_clear),
        .head_data (head_data),
        .occupancy (occupancy)
    );

    // Track reads requested but not yet returned.
    always_ff @(posedge rd_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            out_reg <= '0;
        end else if (rd_en && !rd_accept) begin
            out_reg <= out_reg + CW'(1);
        end else if (!rd_en && rd_accept) begin
            out_reg <= out_reg - CW'(1);
        end
    end

    // Sticky flag for data that arrived with no request outstanding.
    always_ff @(posedge rd_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            err_reg <= 1'b0;
        end else if (unexpected) begin
            err_reg <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge rd_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and flush completion: DRAIN waits out every in-flight word.
    always_comb begin
        state_next = state_reg;
        flush_done = 1'b0;
        case (state_reg)
            RUN: begin
                if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_reg == '0) begin
                    flush_done = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Delivered-word counter, wraps freely.
    always_ff @(posedge rd_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            word_count <= '0;
        end else if (m_valid && m_ready) begin
            word_count <= word_count + 32'd1;
        end
    end

    // Backpressure cycle counter, sticks at all-ones.
    always_ff @(posedge rd_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            stall_count <= '0;
        end else if (m_valid && !m_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
